// File: rtl/uart_tx_arb.sv
// Two-requester round-robin packet arbiter feeding a single UART transmitter.
// Each grant frames a 16-bit payload as {header, msb, lsb} and sends it byte by byte.
`timescale 1ns/1ps
module uart_tx_arb #(
  parameter logic [12:0] BAUD_CNT = 13'd433,
  parameter logic [7:0]  HDR0     = 8'hA5,
  parameter logic [7:0]  HDR1     = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        pkt_done,
  output logic        busy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [12:0] baud_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StArm  = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  logic [1:0]  state_q;
  logic [23:0] pkt_q;
  logic [1:0]  byte_idx_q;
  logic        owner_q;
  logic        last_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        pkt_done_q;

  logic win1;
  logic arb_go;

  // On contention the requester that did not own the previous packet wins.
  assign win1   = req1 & (~req0 | ~last_q);
  assign arb_go = tx_done & (req0 | req1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pkt_q      <= 24'h0;
      byte_idx_q <= 2'd0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arb_go) begin
            owner_q    <= win1;
            byte_idx_q <= 2'd0;
            pkt_q      <= win1 ? {HDR1, data1} : {HDR0, data0};
            gnt0_q     <= ~win1;
            gnt1_q     <= win1;
            state_q    <= StSend;
          end
        end
        StSend: state_q <= StArm;
        // tx_done is still high from the previous idle period; give it a cycle to fall.
        StArm:  state_q <= StWait;
        StWait: begin
          if (tx_done) begin
            if (byte_idx_q == 2'd2) begin
              pkt_done_q <= 1'b1;
              last_q     <= owner_q;
              state_q    <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (byte_idx_q)
      2'd0:    tx_data = pkt_q[23:16];
      2'd1:    tx_data = pkt_q[15:8];
      default: tx_data = pkt_q[7:0];
    endcase
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign pkt_done = pkt_done_q;
  assign busy     = (state_q != StIdle);
  assign trmt     = (state_q == StSend);
  assign baud_cnt = BAUD_CNT;

endmodule
